// File: rtl/rotary_led.sv
// Quadrature rotary-encoder front end: synchronise, debounce and decode the two
// phases, then walk a single lit LED left or right once per detent.
module rotary_led #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clock0,
    input  logic       reset,
    input  logic [1:0] rotary,
    output logic [7:0] leds
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       filt_q, filt_d;
    logic             q1_q, q1_d;
    logic             q2_q, q2_d;
    logic             q1_dly_q, q1_dly_d;
    logic [7:0]       leds_q, leds_d;
    logic             step_s;

    // Next-state logic for the sync chain, debounce filter, phase decode and LED rotation.
    always_comb begin
        sync1_d  = rotary;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        cnt_d    = cnt_q;
        filt_d   = filt_q;
        q1_d     = q1_q;
        q2_d     = q2_q;
        q1_dly_d = q1_q;
        leds_d   = leds_q;
        step_s   = q1_q & ~q1_dly_q;

        // prev_q holds last cycle's sync2, so a run of identical samples is counted here.
        if (sync2_q == prev_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = CNT_ONE;
        end

        if (cnt_d == CNT_MAX) begin
            filt_d = sync2_q;
        end else begin
            filt_d = filt_q;
        end

        case (filt_q)
            2'b11:   q1_d = 1'b1;
            2'b00:   q1_d = 1'b0;
            2'b01:   q2_d = 1'b1;
            2'b10:   q2_d = 1'b0;
            default: q1_d = q1_q;
        endcase

        // Direction is whatever q2 holds when q1 rises.
        if (step_s) begin
            if (q2_q) begin
                leds_d = {leds_q[6:0], leds_q[7]};
            end else begin
                leds_d = {leds_q[0], leds_q[7:1]};
            end
        end else begin
            leds_d = leds_q;
        end
    end

    // State registers; reset returns the display to the first LED.
    always_ff @(posedge clock0 or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 2'b00;
            sync2_q  <= 2'b00;
            prev_q   <= 2'b00;
            cnt_q    <= '0;
            filt_q   <= 2'b00;
            q1_q     <= 1'b0;
            q2_q     <= 1'b0;
            q1_dly_q <= 1'b0;
            leds_q   <= 8'h01;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            filt_q   <= filt_d;
            q1_q     <= q1_d;
            q2_q     <= q2_d;
            q1_dly_q <= q1_dly_d;
            leds_q   <= leds_d;
        end
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_rotary_led.sv
// Directed, table-driven bench for rotary_led: detent sequences, glitch
// rejection, hold, step latency and reset behaviour.
`timescale 1ns/100ps
module tb_rotary_led;

    logic       clock0 = 1'b0;
    logic       reset;
    logic [1:0] rotary = 2'b00;
    logic [7:0] leds;

    int checks   = 0;
    int failures = 0;

    rotary_led #(.DEBOUNCE(4)) dut (
        .clock0 (clock0),
        .reset  (reset),
        .rotary (rotary),
        .leds   (leds)
    );

    always #2 clock0 = ~clock0;

    typedef struct {
        logic [1:0] rot;
        int         cyc;
        logic [7:0] exp;
    } vec_t;

    vec_t       cw_tab[33];
    vec_t       ccw_tab[9];
    logic [7:0] cw_exp[11];
    logic [7:0] ccw_exp[3];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: leds=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [1:0] v, input int n);
        rotary = v;
        repeat (n) @(negedge clock0);
    endtask

    // Called at a negedge; asserts reset mid-cycle and checks the async response.
    task automatic do_reset(input string name);
        #1 reset = 1'b0;
        rotary = 2'b00;
        #0.5 check(name, leds, 8'h01);
        @(negedge clock0);
        @(negedge clock0);
        reset = 1'b1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        hold(v.rot, v.cyc);
        check(tag, leds, v.exp);
    endtask

    initial begin
        cw_exp  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08};
        ccw_exp = '{8'h80, 8'h40, 8'h20};
        for (int i = 0; i < 11; i++) begin
            cw_tab[3*i]   = '{2'b01, 10, (i == 0) ? 8'h01 : cw_exp[(i == 0) ? 0 : i-1]};
            cw_tab[3*i+1] = '{2'b11, 10, cw_exp[i]};
            cw_tab[3*i+2] = '{2'b00, 10, cw_exp[i]};
        end
        for (int i = 0; i < 3; i++) begin
            ccw_tab[3*i]   = '{2'b10, 10, (i == 0) ? 8'h01 : ccw_exp[(i == 0) ? 0 : i-1]};
            ccw_tab[3*i+1] = '{2'b11, 10, ccw_exp[i]};
            ccw_tab[3*i+2] = '{2'b00, 10, ccw_exp[i]};
        end

        // Power-on reset, asserted before any clock edge.
        reset = 1'b1;
        #0.5 reset = 1'b0;
        #0.5 check("reset_async", leds, 8'h01);
        @(negedge clock0);
        @(negedge clock0);
        reset = 1'b1;
        hold(2'b00, 12);
        check("reset_idle", leds, 8'h01);

        // Clockwise: 11 detents, both phases toggling together on 01->11->00.
        for (int i = 0; i < 33; i++) run_vec($sformatf("cw[%0d]", i), cw_tab[i]);

        // Pulses of 2 and 3 cycles are rejected; 4 cycles is just long enough.
        hold(2'b11, 2);
        hold(2'b00, 12);
        check("glitch_2", leds, 8'h08);
        hold(2'b11, 3);
        hold(2'b00, 12);
        check("glitch_3", leds, 8'h08);
        hold(2'b11, 4);
        hold(2'b00, 12);
        check("pulse_4", leds, 8'h10);

        // Long hold at 11 gives exactly one step.
        hold(2'b11, 10);
        check("hold_10", leds, 8'h20);
        hold(2'b11, 90);
        check("hold_100", leds, 8'h20);
        hold(2'b00, 10);
        check("hold_release", leds, 8'h20);

        // Step lands DEBOUNCE+4 = 8 cycles after 11 is applied.
        hold(2'b01, 10);
        check("lat_pre", leds, 8'h20);
        hold(2'b11, 7);
        check("lat_7", leds, 8'h20);
        hold(2'b11, 1);
        check("lat_8", leds, 8'h40);
        hold(2'b11, 2);
        hold(2'b00, 10);
        check("lat_post", leds, 8'h40);

        // Reset mid-run, with a step pending, aborts it.
        do_reset("reset_run");
        for (int i = 0; i < 12; i++) run_vec($sformatf("cw4[%0d]", i), cw_tab[i]);
        hold(2'b01, 10);
        hold(2'b11, 5);
        do_reset("reset_pending");
        hold(2'b00, 12);
        check("abort_step", leds, 8'h01);
        hold(2'b01, 10);
        hold(2'b11, 10);
        hold(2'b00, 10);
        check("after_reset_cw", leds, 8'h02);

        // Counter-clockwise from reset.
        do_reset("reset_ccw");
        for (int i = 0; i < 9; i++) run_vec($sformatf("ccw[%0d]", i), ccw_tab[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
